// File: rtl/board_state.sv
// Minesweeper 8x8 game-state engine: owns the mine/flag/step/cursor tile maps,
// places mines from an LFSR and applies player actions, detecting win and loss.
module board_state #(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_flag,
  input  logic        btn_step,
  input  logic        btn_start,
  input  logic        load_mines,
  input  logic [63:0] mine_in,
  output logic [63:0] mineMap,
  output logic [63:0] flagMap,
  output logic [63:0] stepMap,
  output logic [63:0] posMap,
  output logic [2:0]  state,
  output logic        busy,
  output logic        game_over,
  output logic        game_won
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLACE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    WON   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] mine_reg, mine_next;
  logic [63:0] flag_reg, flag_next;
  logic [63:0] step_reg, step_next;
  logic [63:0] pos_reg, pos_next;
  logic [5:0]  cursor_reg, cursor_next;
  logic [5:0]  count_reg, count_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [63:0] cursor_bit;
  logic [5:0]  cand;

  assign cursor_bit = 64'h1 << cursor_reg;
  assign cand       = lfsr_reg[5:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      mine_reg   <= '0;
      flag_reg   <= '0;
      step_reg   <= '0;
      pos_reg    <= 64'h1;
      cursor_reg <= '0;
      count_reg  <= '0;
      lfsr_reg   <= LFSR_SEED;
    end else begin
      state_reg  <= state_next;
      mine_reg   <= mine_next;
      flag_reg   <= flag_next;
      step_reg   <= step_next;
      pos_reg    <= pos_next;
      cursor_reg <= cursor_next;
      count_reg  <= count_next;
      lfsr_reg   <= lfsr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mine_next   = mine_reg;
    flag_next   = flag_reg;
    step_next   = step_reg;
    cursor_next = cursor_reg;
    count_next  = count_reg;
    lfsr_next   = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    // A new game may begin from any state except while mines are being placed.
    if (btn_start && state_reg != PLACE) begin
      mine_next   = '0;
      flag_next   = '0;
      step_next   = '0;
      cursor_next = '0;
      count_next  = '0;
      state_next  = PLACE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_mines) begin
            mine_next   = mine_in;
            flag_next   = '0;
            step_next   = '0;
            cursor_next = '0;
            state_next  = PLAY;
          end
        end
        PLACE: begin
          // The cursor tile is kept mine-free so the opening step is safe.
          if (!mine_reg[cand] && cand != cursor_reg) begin
            mine_next[cand] = 1'b1;
            count_next      = count_reg + 6'd1;
            if (count_next == 6'(NUM_MINES)) state_next = PLAY;
          end
        end
        PLAY: begin
          if (btn_step) begin
            if (!flag_reg[cursor_reg] && !step_reg[cursor_reg]) begin
              if (mine_reg[cursor_reg]) begin
                step_next  = step_reg | mine_reg | cursor_bit;
                state_next = LOST;
              end else begin
                step_next = step_reg | cursor_bit;
                if (step_next == ~mine_reg) state_next = WON;
              end
            end
          end else if (btn_flag) begin
            if (!step_reg[cursor_reg]) flag_next[cursor_reg] = ~flag_reg[cursor_reg];
          end else if (btn_up) begin
            if (cursor_reg[5:3] != 3'd0) cursor_next = cursor_reg - 6'd8;
          end else if (btn_down) begin
            if (cursor_reg[5:3] != 3'd7) cursor_next = cursor_reg + 6'd8;
          end else if (btn_left) begin
            if (cursor_reg[2:0] != 3'd0) cursor_next = cursor_reg - 6'd1;
          end else if (btn_right) begin
            if (cursor_reg[2:0] != 3'd7) cursor_next = cursor_reg + 6'd1;
          end
        end
        default: ;
      endcase
    end

    pos_next = 64'h1 << cursor_next;
  end

  assign mineMap   = mine_reg;
  assign flagMap   = flag_reg;
  assign stepMap   = step_reg;
  assign posMap    = pos_reg;
  assign state     = state_reg;
  assign busy      = (state_reg == PLACE);
  assign game_over = (state_reg == LOST);
  assign game_won  = (state_reg == WON);

endmodule

// File: tb/tb_board_state.sv
// Randomized plus directed bench for board_state, checked every cycle against a
// tile-array reference model of the game rules.
module tb_board_state;

  localparam int          NM   = 10;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [63:0] M63  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic        btn_flag = 0, btn_step = 0, btn_start = 0, load_mines = 0;
  logic [63:0] mine_in = '0;
  logic [63:0] mineMap, flagMap, stepMap, posMap;
  logic [2:0]  state;
  logic        busy, game_over, game_won;

  board_state #(.NUM_MINES(NM), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_flag(btn_flag), .btn_step(btn_step), .btn_start(btn_start),
    .load_mines(load_mines), .mine_in(mine_in),
    .mineMap(mineMap), .flagMap(flagMap), .stepMap(stepMap), .posMap(posMap),
    .state(state), .busy(busy), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one bit per tile, cursor as row/column, state as plain int.
  bit m_mine[64];
  bit m_flag[64];
  bit m_step[64];
  int m_row, m_col, m_state, m_count, m_lfsr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input bit a[64]);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = a[i];
    return r;
  endfunction

  task automatic new_game();
    for (int i = 0; i < 64; i++) begin
      m_mine[i] = 0; m_flag[i] = 0; m_step[i] = 0;
    end
    m_row = 0; m_col = 0; m_count = 0; m_state = 1;
  endtask

  task automatic model_step();
    int cur, cand, nl;
    bit all_safe;
    if (!reset) begin
      new_game();
      m_state = 0;
      m_lfsr  = SEED;
      return;
    end
    nl = ((m_lfsr << 1) & 'hFFFF) |
         (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1);
    cur  = m_row * 8 + m_col;
    cand = m_lfsr % 64;
    if (btn_start && m_state != 1) begin
      new_game();
    end else if (m_state == 0) begin
      if (load_mines) begin
        for (int i = 0; i < 64; i++) begin
          m_mine[i] = mine_in[i]; m_flag[i] = 0; m_step[i] = 0;
        end
        m_row = 0; m_col = 0; m_state = 2;
      end
    end else if (m_state == 1) begin
      if (!m_mine[cand] && cand != cur) begin
        m_mine[cand] = 1;
        m_count++;
        if (m_count == NM) m_state = 2;
      end
    end else if (m_state == 2) begin
      if (btn_step) begin
        if (!m_flag[cur] && !m_step[cur]) begin
          m_step[cur] = 1;
          if (m_mine[cur]) begin
            for (int i = 0; i < 64; i++) if (m_mine[i]) m_step[i] = 1;
            m_state = 3;
          end else begin
            all_safe = 1;
            for (int i = 0; i < 64; i++) if (!m_mine[i] && !m_step[i]) all_safe = 0;
            if (all_safe) m_state = 4;
          end
        end
      end else if (btn_flag) begin
        if (!m_step[cur]) m_flag[cur] = !m_flag[cur];
      end else if (btn_up) begin
        if (m_row > 0) m_row--;
      end else if (btn_down) begin
        if (m_row < 7) m_row++;
      end else if (btn_left) begin
        if (m_col > 0) m_col--;
      end else if (btn_right) begin
        if (m_col < 7) m_col++;
      end
    end
    m_lfsr = nl;
  endtask

  task automatic compare_all();
    chk("mineMap", mineMap, pack(m_mine));
    chk("flagMap", flagMap, pack(m_flag));
    chk("stepMap", stepMap, pack(m_step));
    chk("posMap", posMap, 64'h1 << (m_row * 8 + m_col));
    chk("state", 64'(state), 64'(m_state));
    chk("busy", 64'(busy), 64'(m_state == 1));
    chk("game_over", 64'(game_over), 64'(m_state == 3));
    chk("game_won", 64'(game_won), 64'(m_state == 4));
  endtask

  // One clock: model and DUT see the same inputs, then pulses are released.
  task automatic step_clk();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_flag = 0; btn_step = 0; btn_start = 0; load_mines = 0;
    reset = 1;
  endtask

  task automatic do_reset();
    reset = 0;
    step_clk();
  endtask

  task automatic load(input logic [63:0] pattern);
    mine_in = pattern; load_mines = 1;
    step_clk();
  endtask

  task automatic wait_place();
    int k;
    k = 0;
    while (busy && k < 500) begin
      step_clk();
      k++;
    end
    if (k >= 500) chk("place_timeout", 64'(busy), 64'd0);
  endtask

  logic [63:0] saved;

  initial begin
    // Reset and random placement
    do_reset();
    chk("rst_pos", posMap, 64'h1);
    chk("rst_mine", mineMap, 64'h0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    btn_start = 1; step_clk();
    chk("start_busy", 64'(busy), 64'd1);
    wait_place();
    chk("place_count", 64'($countones(mineMap)), 64'(NM));
    chk("place_tile0", 64'(mineMap[0]), 64'd0);
    chk("place_state", 64'(state), 64'd2);
    $display("scenario placement: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Moves and edge clamping
    do_reset();
    load(M63);
    btn_left = 1; step_clk();
    chk("left_clamp", posMap, 64'h1);
    for (int i = 0; i < 7; i++) begin btn_right = 1; step_clk(); end
    for (int i = 0; i < 7; i++) begin btn_down = 1; step_clk(); end
    chk("corner_pos", posMap, M63);
    btn_right = 1; step_clk();
    chk("right_clamp", posMap, M63);
    btn_down = 1; step_clk();
    chk("down_clamp", posMap, M63);
    $display("scenario moves: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Flag / step on a mine
    btn_flag = 1; step_clk();
    chk("flag_set", flagMap, M63);
    btn_step = 1; step_clk();
    chk("flagged_step", stepMap, 64'h0);
    chk("flagged_state", 64'(state), 64'd2);
    btn_flag = 1; step_clk();
    chk("flag_clear", flagMap, 64'h0);
    btn_step = 1; step_clk();
    chk("lose_step", stepMap, M63);
    chk("lose_state", 64'(state), 64'd3);
    chk("lose_over", 64'(game_over), 64'd1);
    btn_left = 1; btn_flag = 1; step_clk();
    chk("lost_frozen_pos", posMap, M63);
    $display("scenario lose: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Step every safe tile for a win
    do_reset();
    load(M63);
    for (int t = 0; t < 63; t++) begin
      if (t == 62) chk("prewin_state", 64'(state), 64'd2);
      btn_step = 1; step_clk();
      if (t == 61) begin
        saved = stepMap;
        btn_left = 1; step_clk();
        btn_step = 1; step_clk();
        chk("restep_same", stepMap, saved);
        btn_right = 1; step_clk();
      end
      if (t == 62) begin
        chk("win_state", 64'(state), 64'd4);
        chk("win_flag", 64'(game_won), 64'd1);
      end else if (t % 8 != 7) begin
        btn_right = 1; step_clk();
      end else begin
        btn_down = 1; step_clk();
        for (int i = 0; i < 7; i++) begin btn_left = 1; step_clk(); end
      end
    end
    $display("scenario win: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Simultaneous step/flag/right at tile 0
    do_reset();
    load(M63);
    btn_step = 1; btn_flag = 1; btn_right = 1; step_clk();
    chk("prio_step", stepMap, 64'h1);
    chk("prio_flag", flagMap, 64'h0);
    chk("prio_pos", posMap, 64'h1);
    $display("scenario priority: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Reset mid-placement; start ignored while placing
    do_reset();
    btn_start = 1; step_clk();
    btn_start = 1; step_clk();
    chk("start_in_place", 64'(state), 64'd1);
    for (int k = 0; k < 100 && $countones(mineMap) < 3 && busy; k++) step_clk();
    chk("three_placed", 64'($countones(mineMap)), 64'd3);
    do_reset();
    chk("midrst_mine", mineMap, 64'h0);
    chk("midrst_pos", posMap, 64'h1);
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_lfsr", 64'(dut.lfsr_reg), 64'(SEED));
    btn_start = 1; step_clk();
    wait_place();
    $display("scenario midreset: compared=%0d mismatched=%0d", n_cmp, n_bad);

    // Random play
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) reset = 0;
      if (m_state == 3 || m_state == 4) btn_start = ($urandom_range(0, 4) == 0);
      else btn_start = (r < 3);
      if (m_state == 0 && $urandom_range(0, 1) == 1) begin
        load_mines = 1;
        mine_in = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      end
      btn_up    = ($urandom_range(0, 5) == 0);
      btn_down  = ($urandom_range(0, 5) == 0);
      btn_left  = ($urandom_range(0, 5) == 0);
      btn_right = ($urandom_range(0, 5) == 0);
      btn_flag  = ($urandom_range(0, 9) == 0);
      btn_step  = ($urandom_range(0, 6) == 0);
      step_clk();
    end
    $display("scenario random: compared=%0d mismatched=%0d", n_cmp, n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
